// File: rtl/ternary_mac_q13_if.sv
// Valid/ready bundle for the ternary MAC lane: term-pair input and sum output.
// The master drives operands and consumes the sum; the slave is the lane.
interface ternary_mac_q13_if #(
    parameter int unsigned NUM_BIT = 13
);
    logic               start;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         r_coef;
    logic [NUM_BIT-1:0] h_coef;
    logic               out_valid;
    logic               out_ready;
    logic [NUM_BIT-1:0] out_sum;
    logic               busy;

    modport master (
        output start,
        output in_valid,
        output r_coef,
        output h_coef,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  busy
    );

    modport slave (
        input  start,
        input  in_valid,
        input  r_coef,
        input  h_coef,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output busy
    );
endinterface

// File: rtl/ternary_mac_q13.sv
// Serial ternary MAC lane: sum(r_i * h_i) mod 2^NUM_BIT over LEN term pairs.
// Optional macro TERNARY_MAC_IN_REG_EN adds a 1-deep operand stage and DRAIN state.
module add_2i13_o13 #(
    parameter int unsigned W = 13
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] s
);
    assign s = a + b;
endmodule

module ternary_mac_q13 #(
    parameter int unsigned NUM_BIT = 13,
    parameter int unsigned LEN     = 701,
    parameter int unsigned CNT_W   = 10
) (
    input logic               clk,
    input logic               rst_n,
    ternary_mac_q13_if.slave  mac
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [NUM_BIT-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               rdy;
    logic               vld;
    logic               bsy;
    logic               xfer;
    logic               last;
    logic               add_en;
    logic [1:0]         r_sel;
    logic [NUM_BIT-1:0] h_sel;
    logic [NUM_BIT-1:0] h_neg;
    logic [NUM_BIT-1:0] t;
    logic [NUM_BIT-1:0] acc_nxt;

    assign xfer = mac.in_valid & rdy;
    assign last = (cnt == CNT_W'(LEN - 1));

`ifdef TERNARY_MAC_IN_REG_EN
    logic [1:0]         r_q;
    logic [NUM_BIT-1:0] h_q;
    logic               v_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 2'b00;
            h_q <= '0;
            v_q <= 1'b0;
        end else begin
            v_q <= xfer;
            if (xfer) begin
                r_q <= mac.r_coef;
                h_q <= mac.h_coef;
            end
        end
    end

    assign r_sel  = r_q;
    assign h_sel  = h_q;
    assign add_en = v_q;
`else
    assign r_sel  = mac.r_coef;
    assign h_sel  = mac.h_coef;
    assign add_en = xfer;
`endif

    // -h as ~h + 1 through its own adder pass
    add_2i13_o13 #(.W(NUM_BIT)) u_neg (
        .a (~h_sel),
        .b (NUM_BIT'(1)),
        .s (h_neg)
    );

    // code 10 is treated like 00: contributes nothing
    always_comb begin
        t = '0;
        unique case (1'b1)
            (r_sel == 2'b01): t = h_sel;
            (r_sel == 2'b11): t = h_neg;
            default:          t = '0;
        endcase
    end

    add_2i13_o13 #(.W(NUM_BIT)) u_acc (
        .a (acc),
        .b (t),
        .s (acc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (state == IDLE && mac.start) begin
            acc <= '0;
            cnt <= '0;
        end else begin
            if (xfer)
                cnt <= cnt + CNT_W'(1);
            if (add_en)
                acc <= acc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (mac.start)
                    state_nxt = ACC;
            end
            ACC: begin
                if (xfer && last) begin
`ifdef TERNARY_MAC_IN_REG_EN
                    state_nxt = DRAIN;
`else
                    state_nxt = HOLD;
`endif
                end
            end
            DRAIN: state_nxt = HOLD;
            HOLD: begin
                if (mac.out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rdy = 1'b0;
        vld = 1'b0;
        bsy = 1'b1;
        unique case (state)
            IDLE:    bsy = 1'b0;
            ACC:     rdy = 1'b1;
            DRAIN:   bsy = 1'b1;
            HOLD:    vld = 1'b1;
            default: bsy = 1'b0;
        endcase
    end

    assign mac.in_ready  = rdy;
    assign mac.out_valid = vld;
    assign mac.busy      = bsy;
    assign mac.out_sum   = acc;
endmodule

// File: tb/tb_ternary_mac_q13.sv
// Directed bench for ternary_mac_q13: LEN=4 lane for the corner cases,
// LEN=701 lane for a full-length run against a running reference sum.
module tb_ternary_mac_q13;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;

`ifdef TERNARY_MAC_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    always #5 clk = ~clk;

    ternary_mac_q13_if #(.NUM_BIT(13)) a ();
    ternary_mac_q13_if #(.NUM_BIT(13)) b ();

    ternary_mac_q13 #(.NUM_BIT(13), .LEN(4), .CNT_W(10)) u4 (
        .clk   (clk),
        .rst_n (rst_n),
        .mac   (a.slave)
    );

    ternary_mac_q13 #(.NUM_BIT(13), .LEN(701), .CNT_W(10)) u701 (
        .clk   (clk),
        .rst_n (rst_n),
        .mac   (b.slave)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go();
        a.start = 1'b1;
        tick();
        a.start = 1'b0;
    endtask

    task automatic send(input logic [1:0] r, input logic [12:0] h);
        int n;
        n = 0;
        a.in_valid = 1'b1;
        a.r_coef = r;
        a.h_coef = h;
        while (!a.in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!a.in_ready)
            check("send_timeout", 32'(a.in_ready), 32'd1);
        tick();
        a.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp);
        for (int i = 1; i < LAT; i++) begin
            check({tag, "_early"}, 32'(a.out_valid), 32'd0);
            tick();
        end
        check({tag, "_ov"}, 32'(a.out_valid), 32'd1);
        check({tag, "_sum"}, 32'(a.out_sum), 32'(exp));
        check({tag, "_rdy"}, 32'(a.in_ready), 32'd0);
    endtask

    task automatic release_out(input string tag);
        a.out_ready = 1'b1;
        tick();
        a.out_ready = 1'b0;
        check({tag, "_idle"}, 32'(a.busy), 32'd0);
        check({tag, "_ovlo"}, 32'(a.out_valid), 32'd0);
    endtask

    initial begin
        logic [12:0] ref_sum;
        logic [1:0]  rr;
        logic [12:0] hh;
        int n;

        a.start = 0; a.in_valid = 0; a.r_coef = 0;
        a.h_coef = 0; a.out_ready = 0;
        b.start = 0; b.in_valid = 0; b.r_coef = 0;
        b.h_coef = 0; b.out_ready = 0;

        #12;
        check("rst_ov", 32'(a.out_valid), 32'd0);
        check("rst_ir", 32'(a.in_ready), 32'd0);
        check("rst_busy", 32'(a.busy), 32'd0);
        check("rst_sum", 32'(a.out_sum), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: basic accumulate, 100+200-50+0
        go();
        check("t1_ir", 32'(a.in_ready), 32'd1);
        check("t1_busy", 32'(a.busy), 32'd1);
        send(2'b01, 13'd100);
        send(2'b01, 13'd200);
        send(2'b11, 13'd50);
        send(2'b00, 13'd999);
        wait_done("t1", 250);
        release_out("t1");

        // 2: wrap; 8191+1-1-8191 lands back on 0
        go();
        send(2'b01, 13'd8191);
        send(2'b01, 13'd1);
        send(2'b11, 13'd1);
        send(2'b11, 13'd8191);
        wait_done("t2a", 0);
        release_out("t2a");
        go();
        for (int i = 0; i < 4; i++)
            send(2'b11, 13'd1);
        wait_done("t2b", 8188);
        release_out("t2b");

        // 3: bubbles on every other cycle, then output back-pressure
        go();
        for (int i = 0; i < 8; i++) begin
            a.in_valid = (i % 2 == 0);
            a.r_coef = 2'b01;
            a.h_coef = (i % 2 == 0) ? 13'(10 * (i / 2 + 1)) : 13'd1000;
            tick();
        end
        a.in_valid = 1'b1;
        a.h_coef = 13'd500;
        check("t3_ov", 32'(a.out_valid), 32'd1);
        check("t3_hold_ir", 32'(a.in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_stall_ov", 32'(a.out_valid), 32'd1);
            check("t3_stall_sum", 32'(a.out_sum), 32'd100);
        end
        a.in_valid = 1'b0;
        release_out("t3");

        // 4: code 10 counts but adds nothing; start in ACC ignored
        go();
        send(2'b10, 13'd77);
        send(2'b01, 13'd5);
        a.start = 1'b1;
        tick();
        a.start = 1'b0;
        send(2'b01, 13'd6);
        send(2'b11, 13'd1);
        wait_done("t4", 10);
        a.start = 1'b1;
        release_out("t4_exit");
        a.start = 1'b0;
        tick();
        check("t4_start_ign", 32'(a.busy), 32'd0);

        // 5: async reset mid-run, then a clean sum
        go();
        send(2'b01, 13'd300);
        send(2'b01, 13'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_ov", 32'(a.out_valid), 32'd0);
        check("t5_ir", 32'(a.in_ready), 32'd0);
        check("t5_busy", 32'(a.busy), 32'd0);
        check("t5_sum", 32'(a.out_sum), 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        check("t5_still_idle", 32'(a.busy), 32'd0);
        go();
        send(2'b01, 13'd7);
        send(2'b01, 13'd7);
        send(2'b11, 13'd2);
        send(2'b00, 13'd3);
        wait_done("t5", 12);
        release_out("t5");

        // 6: full length on the LEN=701 lane
        ref_sum = '0;
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        for (int i = 0; i < 701; i++) begin
            n = $urandom_range(0, 2);
            rr = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
            hh = 13'($urandom);
            if (rr == 2'b01)
                ref_sum = ref_sum + hh;
            else if (rr == 2'b11)
                ref_sum = ref_sum - hh;
            b.in_valid = 1'b1;
            b.r_coef = rr;
            b.h_coef = hh;
            if (!b.in_ready)
                check("t6_ir", 32'(b.in_ready), 32'd1);
            tick();
        end
        b.in_valid = 1'b0;
        for (int i = 1; i < LAT; i++) begin
            check("t6_early", 32'(b.out_valid), 32'd0);
            tick();
        end
        check("t6_ov", 32'(b.out_valid), 32'd1);
        check("t6_sum", 32'(b.out_sum), 32'(ref_sum));
        check("t6_rdy", 32'(b.in_ready), 32'd0);
        b.out_ready = 1'b1;
        tick();
        b.out_ready = 1'b0;
        check("t6_idle", 32'(b.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
